// File: rtl/mem_access_pkg.sv
// Shared size codes, FSM state encoding and alignment rule for the data-memory access unit.
package mem_access_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ      = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_RMW_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  // Reserved size code 2'b11 is treated as misaligned so it takes the error path.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction (with sign/zero extension) and sub-word merge for read-modify-write stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] lane_raw;

  always_comb begin
    // Offset 0 is the most significant lane, so the shift shrinks as the offset grows.
    lane_mask = 32'h0000_00ff;
    shamt     = {~offset, 3'b000};
    if (size == SZ_HALF) begin
      lane_mask = 32'h0000_ffff;
      shamt     = {~offset[1], 4'b0000};
    end else if (size == SZ_WORD) begin
      lane_mask = 32'hffff_ffff;
      shamt     = 5'd0;
    end

    lane_raw  = (word >> shamt) & lane_mask;
    load_data = lane_raw;
    if (!is_unsigned) begin
      if (size == SZ_BYTE && lane_raw[7]) begin
        load_data = lane_raw | 32'hffff_ff00;
      end else if (size == SZ_HALF && lane_raw[15]) begin
        load_data = lane_raw | 32'hffff_0000;
      end
    end

    merged = (word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the 256x8 big-endian data memory: one request in flight,
// sub-word stores via read-modify-write, misaligned/reserved requests answered with an error.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        off_q, off_d;
  size_t             size_q, size_d;
  logic              write_q, write_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [31:0] load_data;
  logic [31:0] merged;

  mem_lane_align u_align (
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    write_d    = write_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d   = req_addr[1:0];
          size_d  = req_size;
          write_d = req_write;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            state_d    = (req_write && req_size == SZ_WORD) ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_READ: begin
        // wdata_q doubles as the merged-word holder for the RMW write cycle.
        if (write_q) begin
          wdata_d = merged;
          state_d = ST_RMW_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE, ST_RMW_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      off_q      <= 2'b00;
      size_q     <= SZ_BYTE;
      write_q    <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      write_q    <= write_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_read   = (state_q == ST_READ);
  // A write cycle overlapping reset must not reach the memory.
  assign mem_write  = (state_q == ST_WRITE || state_q == ST_RMW_WRITE) && !reset;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural big-endian 256x8 memory plus a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Memory seen by the DUT, plus a back-door port used to preload it.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       bd_en = 1'b0;
  logic [7:0] bd_addr = 8'h00;
  logic [7:0] bd_data = 8'h00;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, unal_cnt = 0;

  assign mem_rdata = {mem[mem_addr], mem[mem_addr + 8'd1], mem[mem_addr + 8'd2], mem[mem_addr + 8'd3]};

  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_write) begin
      mem[mem_addr]        <= mem_wdata[31:24];
      mem[mem_addr + 8'd1] <= mem_wdata[23:16];
      mem[mem_addr + 8'd2] <= mem_wdata[15:8];
      mem[mem_addr + 8'd3] <= mem_wdata[7:0];
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if ((mem_read || mem_write) && mem_addr[1:0] != 2'b00) unal_cnt <= unal_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'b11) || (sz == 2'b10 && (a % 4) != 0) || (sz == 2'b01 && (a % 2) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [7:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[8'(int'(a) + i)]);
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
    int n;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) ref_mem[8'(int'(a) + i)] = 8'(wd >> (8*(n-1-i)));
  endtask

  function automatic int expected_latency(input logic w, input logic [1:0] sz, input logic [7:0] a);
    if (model_err(sz, a)) return 1;
    if (w && sz != 2'b10) return 3;
    return 2;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int nrd, output int nwr);
    int rd0, wr0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
    $display("txn w=%0d sz=%0d u=%0d addr=%02h wdata=%08h -> rdata=%08h err=%0d lat=%0d rd=%0d wr=%0d",
             w, sz, u, a, wd, rd, er, lat, nrd, nwr);
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d memory bytes differ, required 0", name, bad);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/vld/err/rd/wr=%b required 10000",
               {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    n_vec++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 72'h0) begin
      n_err++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h required zeros", resp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hdeadbeef, rd, er, lat, nrd, nwr);
    model_store(2'b10, 8'h10, 32'hdeadbeef);
    n_vec++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hdeadbeef) begin
      n_err++;
      $display("FAIL sw_bytes: got %h%h%h%h required deadbeef", mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
    n_vec++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      n_err++;
      $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h required 2/0/0", lat, er, rd);
    end
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nrd, nwr);
    n_vec++;
    if (rd !== 32'hdeadbeef || er !== 1'b0 || lat !== 2) begin
      n_err++;
      $display("FAIL lw_resp: got rdata=%h err=%b lat=%0d required deadbeef/0/2", rd, er, lat);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(1'b1, 2'b00, 1'b0, 8'h12, 32'h00000055, rd, er, lat, nrd, nwr);
    model_store(2'b00, 8'h12, 32'h55);
    n_vec++;
    if (lat !== 3 || nrd !== 1 || nwr !== 1 || er !== 1'b0) begin
      n_err++;
      $display("FAIL sb_timing: got lat=%0d reads=%0d writes=%0d err=%b required 3/1/1/0", lat, nrd, nwr, er);
    end
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nrd, nwr);
    n_vec++;
    if (rd !== 32'hdead55ef) begin
      n_err++;
      $display("FAIL sb_readback: got %h required dead55ef", rd);
    end
    bd_write(8'h12, 8'hbe);
    do_req(1'b1, 2'b01, 1'b0, 8'h10, 32'h00001234, rd, er, lat, nrd, nwr);
    model_store(2'b01, 8'h10, 32'h1234);
    n_vec++;
    if (lat !== 3 || nrd !== 1 || nwr !== 1) begin
      n_err++;
      $display("FAIL sh_timing: got lat=%0d reads=%0d writes=%0d required 3/1/1", lat, nrd, nwr);
    end
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nrd, nwr);
    n_vec++;
    if (rd !== 32'h1234beef) begin
      n_err++;
      $display("FAIL sh_readback: got %h required 1234beef", rd);
    end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    logic [1:0]  szs [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  adr [4] = '{8'h20, 8'h20, 8'h20, 8'h22};
    logic [31:0] exp [4] = '{32'hffffff80, 32'h00000080, 32'hffff80ff, 32'h00007f01};
    bd_write(8'h20, 8'h80); bd_write(8'h21, 8'hff); bd_write(8'h22, 8'h7f); bd_write(8'h23, 8'h01);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, szs[i], uns[i], adr[i], 32'h0, rd, er, lat, nrd, nwr);
      n_vec++;
      if (rd !== exp[i] || lat !== 2) begin
        n_err++;
        $display("FAIL extend_%0d: got rdata=%h lat=%0d required %h/2", i, rd, lat, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    logic        ws  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  szs [3] = '{2'b10, 2'b01, 2'b11};
    logic [7:0]  adr [3] = '{8'h11, 8'h13, 8'h00};
    for (int i = 0; i < 3; i++) begin
      do_req(ws[i], szs[i], 1'b0, adr[i], 32'hcafef00d, rd, er, lat, nrd, nwr);
      n_vec++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nrd !== 0 || nwr !== 0) begin
        n_err++;
        $display("FAIL error_%0d: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d required 1/0/1/0/0",
                 i, er, rd, lat, nrd, nwr);
      end
    end
    check_mem("error_mem_unchanged");
  endtask

  task automatic test_reset_mid_rmw();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 8'h30;
    req_wdata = 32'h000000aa;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL rmw_phase: got mem_write=%b required 1 before reset", mem_write);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_gate: got mem_write=%b required 0 under reset", mem_write);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    $display("txn reset during rmw of sb @30");
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_reset_state: got ready=%b valid=%b required 1/0", req_ready, resp_valid);
    end
    n_vec++;
    if (mem[8'h30] !== ref_mem[8'h30]) begin
      n_err++;
      $display("FAIL rmw_reset_mem: got %h required %h", mem[8'h30], ref_mem[8'h30]);
    end
  endtask

  task automatic test_top_address();
    logic [31:0] rd, wd; logic er; int lat, nrd, nwr;
    wd = $urandom;
    do_req(1'b1, 2'b10, 1'b0, 8'hfc, wd, rd, er, lat, nrd, nwr);
    model_store(2'b10, 8'hfc, wd);
    check_mem("sw_fc_mem");
    do_req(1'b0, 2'b10, 1'b0, 8'hfc, 32'h0, rd, er, lat, nrd, nwr);
    n_vec++;
    if (rd !== wd || er !== 1'b0) begin
      n_err++;
      $display("FAIL lw_fc: got rdata=%h err=%b required %h/0", rd, er, wd);
    end
  endtask

  task automatic test_stall();
    logic [31:0] cap, exp;
    int waited;
    exp = model_load(2'b01, 1'b0, 8'h20);
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 8'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    while (!resp_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    cap = resp_rdata;
    n_vec++;
    if (cap !== exp || resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_first: got valid=%b rdata=%h required 1/%h", resp_valid, cap, exp);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 8'h40; req_wdata = $urandom;
      @(posedge clk); #1;
      n_vec++;
      if (resp_valid !== 1'b1 || resp_rdata !== cap || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got valid=%b rdata=%h ready=%b required 1/%h/0",
                 i, resp_valid, resp_rdata, req_ready, cap);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    $display("txn stalled lh @20 -> rdata=%08h held 4 cycles", cap);
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: got ready=%b valid=%b required 1/0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_no_accept: got rd=%b wr=%b ready=%b required 0/0/1", mem_read, mem_write, req_ready);
    end
    check_mem("stall_mem");
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd; logic er, w, u; logic [1:0] sz; logic [7:0] a;
    int lat, nrd, nwr, r, exp_rdn, exp_wrn;
    for (int t = 0; t < 150; t++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      exp_rd  = (w || model_err(sz, a)) ? 32'h0 : model_load(sz, u, a);
      exp_rdn = (model_err(sz, a) || (w && sz == 2'b10)) ? 0 : 1;
      exp_wrn = (model_err(sz, a) || !w) ? 0 : 1;
      do_req(w, sz, u, a, wd, rd, er, lat, nrd, nwr);
      if (w && !model_err(sz, a)) model_store(sz, a, wd);
      n_vec++;
      if (rd !== exp_rd || er !== model_err(sz, a) || lat !== expected_latency(w, sz, a)
          || nrd !== exp_rdn || nwr !== exp_wrn) begin
        n_err++;
        $display("FAIL random_%0d: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d required %h/%b/%0d/%0d/%0d",
                 t, rd, er, lat, nrd, nwr, exp_rd, model_err(sz, a), expected_latency(w, sz, a),
                 exp_rdn, exp_wrn);
      end
    end
    check_mem("random_mem");
    n_vec++;
    if (both_cnt !== 0 || unal_cnt !== 0) begin
      n_err++;
      $display("FAIL port_rules: got both_high=%0d unaligned_addr=%0d required 0/0", both_cnt, unal_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_store();
    test_extend();
    test_errors();
    test_reset_mid_rmw();
    test_top_address();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
